// File: rtl/dict_codec_if.sv
// Bus bundle for the dictionary codec: command/data inputs and result outputs.
// The codec itself takes the slave view; a driver (or bench) takes the master view.
interface dict_codec_if #(
  parameter int DATA_W = 80,
  parameter int CODE_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic [CODE_W-1:0] compressed_in;
  logic [1:0]        command;
  logic [CODE_W-1:0] compressed_out;
  logic [DATA_W-1:0] decompressed_out;
  logic [1:0]        response;
  logic              busy;
  logic [CODE_W:0]   count;

  modport master (
    output data_in, compressed_in, command,
    input  compressed_out, decompressed_out, response, busy, count
  );

  modport slave (
    input  data_in, compressed_in, command,
    output compressed_out, decompressed_out, response, busy, count
  );
endinterface

// File: rtl/dict_codec.sv
// Dictionary codec: maps DATA_W-bit words to CODE_W-bit codes by a linear
// search over a DEPTH-entry dictionary, one entry per cycle.
// Optional build macro DICT_EVICT_EN: when defined, a miss on a full dictionary
// overwrites entries round-robin; when undefined it reports ERR instead.
//
// state  | meaning
// IDLE   | ready for a command; DECOMPRESS and CLEAR complete here in one edge
// SEARCH | comparing entry k against the latched word
// WRITE  | empty dictionary: store the latched word at index 0
module dict_codec #(
  parameter int DATA_W = 80,
  parameter int CODE_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic         clk,
  input  logic         reset,
  dict_codec_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CODE_W:0] DEPTH_CNT = (CODE_W+1)'(DEPTH);

  localparam logic [1:0] CMD_COMPRESS   = 2'b01;
  localparam logic [1:0] CMD_DECOMPRESS = 2'b10;
  localparam logic [1:0] CMD_CLEAR      = 2'b11;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_NEW  = 2'b10;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  typedef enum logic [1:0] {IDLE, SEARCH, WRITE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [CODE_W:0]   count_q, count_d;
  logic [CODE_W-1:0] cout_q, cout_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [1:0]        resp_q, resp_d;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic              hit, last, full;

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef DICT_EVICT_EN
  logic [IDX_W-1:0]  evict_q, evict_d;
`endif

  assign hit  = (mem[k_q] == word_q);
  assign last = ((CODE_W+1)'(k_q) == count_q - 1'b1);
  assign full = (count_q == DEPTH_CNT);

  assign bus.busy             = (state_q != IDLE);
  assign bus.count            = count_q;
  assign bus.compressed_out   = cout_q;
  assign bus.decompressed_out = dout_q;
  assign bus.response         = resp_q;

  // Next-state and result computation; response defaults to NONE so it pulses.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    word_d  = word_q;
    count_d = count_q;
    cout_d  = cout_q;
    dout_d  = dout_q;
    resp_d  = RESP_NONE;
    wr_en   = 1'b0;
    wr_idx  = count_q[IDX_W-1:0];
`ifdef DICT_EVICT_EN
    evict_d = evict_q;
`endif
    case (state_q)
      IDLE: begin
        case (bus.command)
          CMD_COMPRESS: begin
            word_d  = bus.data_in;
            k_d     = '0;
            state_d = (count_q == '0) ? WRITE : SEARCH;
          end
          CMD_DECOMPRESS: begin
            if ({1'b0, bus.compressed_in} < count_q) begin
              dout_d = mem[bus.compressed_in[IDX_W-1:0]];
              resp_d = RESP_OK;
            end else begin
              resp_d = RESP_ERR;
            end
          end
          CMD_CLEAR: begin
            count_d = '0;
`ifdef DICT_EVICT_EN
            evict_d = '0;
`endif
            resp_d  = RESP_OK;
          end
          default: ;
        endcase
      end
      SEARCH: begin
        if (hit) begin
          cout_d  = CODE_W'(k_q);
          resp_d  = RESP_OK;
          state_d = IDLE;
        end else if (last) begin
          state_d = IDLE;
          if (!full) begin
            wr_en   = 1'b1;
            cout_d  = count_q[CODE_W-1:0];
            count_d = count_q + 1'b1;
            resp_d  = RESP_NEW;
          end else begin
`ifdef DICT_EVICT_EN
            wr_en   = 1'b1;
            wr_idx  = evict_q;
            cout_d  = CODE_W'(evict_q);
            resp_d  = RESP_NEW;
            evict_d = (evict_q == IDX_W'(DEPTH - 1)) ? '0 : evict_q + 1'b1;
`else
            resp_d  = RESP_ERR;
`endif
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      WRITE: begin
        wr_en   = 1'b1;
        cout_d  = count_q[CODE_W-1:0];
        count_d = count_q + 1'b1;
        resp_d  = RESP_NEW;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      word_q  <= '0;
      count_q <= '0;
      cout_q  <= '0;
      dout_q  <= '0;
      resp_q  <= RESP_NONE;
`ifdef DICT_EVICT_EN
      evict_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      word_q  <= word_d;
      count_q <= count_d;
      cout_q  <= cout_d;
      dout_q  <= dout_d;
      resp_q  <= resp_d;
`ifdef DICT_EVICT_EN
      evict_q <= evict_d;
`endif
    end
  end

  // Dictionary storage is not reset; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (reset && wr_en) mem[wr_idx] <= word_q;
  end

endmodule

// File: tb/tb_dict_codec.sv
// Directed bench for dict_codec with a 4-entry dictionary, so both the normal
// paths and the full-dictionary policy (with or without DICT_EVICT_EN) are hit.
module tb_dict_codec;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;

  dict_codec_if #(.DATA_W(80), .CODE_W(8)) bus ();

  dict_codec #(.DATA_W(80), .CODE_W(8), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compress(input string tag, input logic [79:0] d, input int lat,
                          input logic [1:0] resp, input logic [7:0] code);
    int n;
    bus.command = 2'b01;
    bus.data_in = d;
    tick();
    bus.command = 2'b00;
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 80'(n), 80'(lat));
    check({tag, " resp"}, 80'(bus.response), 80'(resp));
    check({tag, " code"}, 80'(bus.compressed_out), 80'(code));
  endtask

  task automatic decompress(input string tag, input logic [7:0] code,
                            input logic [1:0] resp, input logic [79:0] word);
    bus.command       = 2'b10;
    bus.compressed_in = code;
    tick();
    bus.command = 2'b00;
    check({tag, " resp"}, 80'(bus.response), 80'(resp));
    check({tag, " word"}, bus.decompressed_out, word);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b0;
    bus.command       = 2'b00;
    bus.data_in       = '0;
    bus.compressed_in = '0;
    tick();
    tick();
    check("rst busy", 80'(bus.busy), 80'(0));
    check("rst count", 80'(bus.count), 80'(0));
    check("rst resp", 80'(bus.response), 80'(0));
    check("rst cout", 80'(bus.compressed_out), 80'(0));
    check("rst dout", bus.decompressed_out, 80'(0));
    reset = 1'b1;

    // fill with 1,2,3: codes 0,1,2 after 1,1,2 cycles
    compress("c1", 80'h1, 1, 2'b10, 8'd0);
    compress("c2", 80'h2, 1, 2'b10, 8'd1);
    compress("c3", 80'h3, 2, 2'b10, 8'd2);
    check("count3", 80'(bus.count), 80'(3));
    tick();
    check("resp pulse", 80'(bus.response), 80'(0));
    check("cout hold", 80'(bus.compressed_out), 80'(2));

    // hit on entry 1
    compress("hit2", 80'h2, 2, 2'b01, 8'd1);
    check("hit count", 80'(bus.count), 80'(3));

    decompress("dec2", 8'd2, 2'b01, 80'h3);
    decompress("dec5", 8'd5, 2'b11, 80'h3);
    decompress("dec3", 8'd3, 2'b11, 80'h3);
    decompress("dec0", 8'd0, 2'b01, 80'h1);

    // reset two cycles into a search; a command held during reset is dropped
    bus.command = 2'b01;
    bus.data_in = 80'h9;
    tick();
    tick();
    check("search busy", 80'(bus.busy), 80'(1));
    reset = 1'b0;
    tick();
    check("abort busy", 80'(bus.busy), 80'(0));
    check("abort count", 80'(bus.count), 80'(0));
    check("abort resp", 80'(bus.response), 80'(0));
    reset       = 1'b1;
    bus.command = 2'b00;
    tick();
    check("post abort resp", 80'(bus.response), 80'(0));
    check("post abort busy", 80'(bus.busy), 80'(0));
    check("post abort count", 80'(bus.count), 80'(0));

    // fill to DEPTH=4
    compress("f1", 80'h1, 1, 2'b10, 8'd0);
    compress("f2", 80'h2, 1, 2'b10, 8'd1);
    compress("f3", 80'h3, 2, 2'b10, 8'd2);
    compress("f4", 80'h4, 3, 2'b10, 8'd3);
    check("full count", 80'(bus.count), 80'(4));
    compress("hit4", 80'h4, 4, 2'b01, 8'd3);
`ifdef DICT_EVICT_EN
    compress("evict5", 80'h5, 4, 2'b10, 8'd0);
    compress("evict6", 80'h6, 4, 2'b10, 8'd1);
    check("evict count", 80'(bus.count), 80'(4));
    decompress("dec ev0", 8'd0, 2'b01, 80'h5);
    decompress("dec ev1", 8'd1, 2'b01, 80'h6);
`else
    compress("full5", 80'h5, 4, 2'b11, 8'd3);
    check("full5 count", 80'(bus.count), 80'(4));
    decompress("dec full3", 8'd3, 2'b01, 80'h4);
`endif

    // clear, then the next word lands at code 0 after one cycle
    bus.command = 2'b11;
    tick();
    bus.command = 2'b00;
    check("clear resp", 80'(bus.response), 80'(1));
    check("clear count", 80'(bus.count), 80'(0));
    compress("c7", 80'h7, 1, 2'b10, 8'd0);
    check("c7 count", 80'(bus.count), 80'(1));

    // COMPRESS held with data_in stepping every cycle
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.command = 2'b01;
    for (int i = 0; i < 7; i++) begin
      bus.data_in = 80'(100 + i);
      tick();
    end
    bus.command = 2'b00;
    check("hold resp", 80'(bus.response), 80'(2));
    check("hold cout", 80'(bus.compressed_out), 80'(2));
    check("hold count", 80'(bus.count), 80'(3));
    check("hold busy", 80'(bus.busy), 80'(0));
    decompress("hold d0", 8'd0, 2'b01, 80'd100);
    decompress("hold d1", 8'd1, 2'b01, 80'd102);
    decompress("hold d2", 8'd2, 2'b01, 80'd104);
    compress("hold dup", 80'd102, 2, 2'b01, 8'd1);
    check("dup count", 80'(bus.count), 80'(3));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
